// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared state encoding for the unified-memory arbiter.
package memory_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;
endpackage

// File: rtl/memory_arbiter_timeout_counter.sv
// arb_timeout_counter: counts cycles of an outstanding memory access and flags expiry at TIMEOUT.
module arb_timeout_counter #(
  parameter int TIMEOUT = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT + 1);
  logic [W-1:0] cnt;
  assign expired = cnt == W'(TIMEOUT);
  always_ff @(posedge clock or negedge reset)
    if (!reset) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en && !expired) cnt <= cnt + 1'b1;
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one single-port memory between the fetch and data ports with
// req/ack sequencing, bounded data-over-fetch priority and an access timeout.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic [WIDTH-1:0] if_rdata,
  output logic             if_valid,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [WIDTH-1:0] d_addr,
  input  logic [WIDTH-1:0] d_wdata,
  output logic [WIDTH-1:0] d_rdata,
  output logic             d_valid,
  output logic             bus_err,
  output logic             mem_req,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack
);
  localparam int RW = MAX_DATA_RUN > 0 ? $clog2(MAX_DATA_RUN + 1) : 1;
  state_t state, state_n;
  logic [RW-1:0] run, run_n;
  logic ifr, dr, done, expired;
  // a port whose completion is pulsing this cycle is still holding req; ignore it
  assign ifr  = if_req && !if_valid;
  assign dr   = d_req && !d_valid;
  assign done = state != IDLE && (mem_ack || expired);
  arb_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clock   (clock),
    .reset   (reset),
    .clr     (state == IDLE),
    .en      (state != IDLE),
    .expired (expired)
  );
  always_comb begin
    state_n = state;
    run_n   = run;
    if (state == IDLE) begin
      if (dr && (!ifr || run < RW'(MAX_DATA_RUN))) begin
        state_n = DATA;
        run_n   = ifr ? run + 1'b1 : '0;
      end else if (ifr) begin
        state_n = FETCH;
        run_n   = '0;
      end
    end else if (done) state_n = IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= IDLE;
      run   <= '0;
    end else begin
      state <= state_n;
      run   <= run_n;
    end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      d_rdata   <= '0;
      d_valid   <= 1'b0;
      bus_err   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      bus_err  <= 1'b0;
      if (state == IDLE && state_n != IDLE) begin
        mem_req   <= 1'b1;
        mem_we    <= state_n == DATA && d_we;
        mem_addr  <= state_n == DATA ? d_addr : if_addr;
        mem_wdata <= state_n == DATA ? d_wdata : '0;
      end else if (done) begin
        mem_req <= 1'b0;
        bus_err <= !mem_ack;
        if (state == FETCH) begin
          if_valid <= 1'b1;
          if_rdata <= mem_ack ? mem_rdata : '0;
        end else begin
          d_valid <= 1'b1;
          if (!mem_ack || !mem_we) d_rdata <= mem_ack ? mem_rdata : '0;
        end
      end
    end
endmodule
